// File: rtl/risc_prog_loader_pkg.sv
//==============================================================================
// Module      : risc_loader_pkg
// Description : Shared types and constants for the risc program loader.
//               Holds the loader FSM state encoding, the default frame
//               start byte and the instruction-bus widths shared with the
//               top-level wrapper of the risc core.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package risc_loader_pkg;

    // Instruction-memory address width and data / byte-stream width.
    localparam int LOADER_ADDR_W = 7;
    localparam int LOADER_DATA_W = 8;

    // Byte that opens every frame.
    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    // Loader FSM states. ST_CSUM is only reachable when the checksum
    // feature is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_WR   = 3'd4,
        ST_CSUM = 3'd5
    } state_t;

endpackage : risc_loader_pkg

`default_nettype wire

// File: rtl/risc_prog_loader_if.sv
//==============================================================================
// Module      : risc_prog_loader_if
// Description : Bundle of the host byte stream, the instruction-memory
//               write port and the loader status flags.
//               master : the loader (accepts bytes, drives the write port)
//               slave  : the surroundings (host pins and risc core)
//   byte_in/byte_valid/byte_ready : host byte handshake
//   abort                         : synchronous frame abort
//   inst_we/inst_address/inst_data: instruction-memory write port
//   busy/done/csum_err            : loader status
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface risc_prog_loader_if
    import risc_loader_pkg::*;
#(
    parameter int ADDR_W = LOADER_ADDR_W,
    parameter int DATA_W = LOADER_DATA_W
);

    logic [DATA_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              abort;
    logic              inst_we;
    logic [ADDR_W-1:0] inst_address;
    logic [DATA_W-1:0] inst_data;
    logic              busy;
    logic              done;
    logic              csum_err;

    modport master (
        input  byte_in,
        input  byte_valid,
        input  abort,
        output byte_ready,
        output inst_we,
        output inst_address,
        output inst_data,
        output busy,
        output done,
        output csum_err
    );

    modport slave (
        output byte_in,
        output byte_valid,
        output abort,
        input  byte_ready,
        input  inst_we,
        input  inst_address,
        input  inst_data,
        input  busy,
        input  done,
        input  csum_err
    );

endinterface : risc_prog_loader_if

`default_nettype wire

// File: rtl/risc_prog_loader.sv
//==============================================================================
// Module      : risc_prog_loader
// Description : Byte-stream program loader for the risc instruction memory.
//               Parses frames  SYNC, LEN, ADDR, LEN data bytes [, CSUM]
//               and issues one instruction-memory write per data byte with
//               an auto-incrementing 7-bit address (wraps 127 -> 0).
//               LEN = 0 encodes 128 bytes; ADDR bit 7 is ignored.
// Ports       : clk   - single clock, rising edge
//               rst_n - synchronous active-low reset
//               bus   - risc_prog_loader_if.master (byte stream, write port,
//                       busy / done / csum_err status)
// Options     : RISC_LOADER_CSUM_EN - when defined, frames carry a trailing
//               checksum byte (sum of data bytes mod 256) and csum_err
//               reports a mismatch; otherwise csum_err is tied to 0 and the
//               frame ends after the last data write.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module risc_prog_loader
    import risc_loader_pkg::*;
#(
    parameter int                ADDR_W = LOADER_ADDR_W,
    parameter int                DATA_W = LOADER_DATA_W,
    parameter logic [DATA_W-1:0] SYNC   = LOADER_SYNC
) (
    input  logic               clk,
    input  logic               rst_n,
    risc_prog_loader_if.master bus
);

    // Remaining-byte counter needs one extra bit to hold the full 2**ADDR_W
    // count that LEN = 0 stands for.
    localparam int               CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] C_MAX_LEN = CNT_W'(1) << ADDR_W;

    state_t              r_state;
    state_t              w_state_nx;
    logic [CNT_W-1:0]    r_remain;
    logic [CNT_W-1:0]    w_remain_nx;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nx;
    logic                r_we;
    logic                w_we_nx;
    logic [ADDR_W-1:0]   r_inst_address;
    logic [ADDR_W-1:0]   w_inst_address_nx;
    logic [DATA_W-1:0]   r_inst_data;
    logic [DATA_W-1:0]   w_inst_data_nx;
    logic                r_done;
    logic                w_done_nx;
    logic                w_ready;
    logic                w_accept;
`ifdef RISC_LOADER_CSUM_EN
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   w_acc_nx;
    logic                r_csum_err;
    logic                w_csum_err_nx;
`endif

    // Ready depends on state only (never on byte_valid). It is also held
    // low while reset is asserted so every output reads 0 during reset,
    // and rises in the very first cycle after release.
    assign w_ready  = rst_n && (r_state != ST_WR);
    assign w_accept = bus.byte_valid && w_ready;

    //--------------------------------------------------------------------------
    // Next-state and datapath logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nx        = r_state;
        w_remain_nx       = r_remain;
        w_addr_nx         = r_addr;
        w_we_nx           = 1'b0;
        w_inst_address_nx = r_inst_address;
        w_inst_data_nx    = r_inst_data;
        w_done_nx         = 1'b0;
`ifdef RISC_LOADER_CSUM_EN
        w_acc_nx          = r_acc;
        w_csum_err_nx     = r_csum_err;
`endif

        if (bus.abort) begin
            // Abort wins over a byte offered in the same cycle; no done
            // pulse, checksum flag left as it was.
            w_state_nx = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Anything other than SYNC is silently dropped.
                    if (w_accept && (bus.byte_in == SYNC)) begin
                        w_state_nx    = ST_LEN;
`ifdef RISC_LOADER_CSUM_EN
                        w_csum_err_nx = 1'b0;
`endif
                    end
                end

                ST_LEN: begin
                    if (w_accept) begin
                        w_remain_nx = (bus.byte_in == '0) ? C_MAX_LEN
                                                          : CNT_W'(bus.byte_in);
                        w_state_nx  = ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (w_accept) begin
                        // Upper bits of the address byte are ignored.
                        w_addr_nx  = bus.byte_in[ADDR_W-1:0];
`ifdef RISC_LOADER_CSUM_EN
                        w_acc_nx   = '0;
`endif
                        w_state_nx = ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_accept) begin
                        w_inst_address_nx = r_addr;
                        w_inst_data_nx    = bus.byte_in;
                        w_we_nx           = 1'b1;
                        w_remain_nx       = r_remain - CNT_W'(1);
`ifdef RISC_LOADER_CSUM_EN
                        w_acc_nx          = r_acc + bus.byte_in;
`endif
                        w_state_nx        = ST_WR;
                    end
                end

                ST_WR: begin
                    // Write strobe is visible this cycle; step the address
                    // (natural wrap at the top of the address space).
                    w_addr_nx = r_addr + ADDR_W'(1);
                    if (r_remain == '0) begin
`ifdef RISC_LOADER_CSUM_EN
                        w_state_nx = ST_CSUM;
`else
                        w_state_nx = ST_IDLE;
                        w_done_nx  = 1'b1;
`endif
                    end else begin
                        w_state_nx = ST_DATA;
                    end
                end

`ifdef RISC_LOADER_CSUM_EN
                ST_CSUM: begin
                    if (w_accept) begin
                        w_csum_err_nx = (bus.byte_in != r_acc);
                        w_done_nx     = 1'b1;
                        w_state_nx    = ST_IDLE;
                    end
                end
`endif

                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // State and output registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_remain       <= '0;
            r_addr         <= '0;
            r_we           <= 1'b0;
            r_inst_address <= '0;
            r_inst_data    <= '0;
            r_done         <= 1'b0;
`ifdef RISC_LOADER_CSUM_EN
            r_acc          <= '0;
            r_csum_err     <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nx;
            r_remain       <= w_remain_nx;
            r_addr         <= w_addr_nx;
            r_we           <= w_we_nx;
            r_inst_address <= w_inst_address_nx;
            r_inst_data    <= w_inst_data_nx;
            r_done         <= w_done_nx;
`ifdef RISC_LOADER_CSUM_EN
            r_acc          <= w_acc_nx;
            r_csum_err     <= w_csum_err_nx;
`endif
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bus.byte_ready   = w_ready;
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.inst_we      = r_we;
    assign bus.inst_address = r_inst_address;
    assign bus.inst_data    = r_inst_data;
    assign bus.done         = r_done;
`ifdef RISC_LOADER_CSUM_EN
    assign bus.csum_err     = r_csum_err;
`else
    assign bus.csum_err     = 1'b0;
`endif

endmodule : risc_prog_loader

`default_nettype wire

// File: doc/risc_prog_loader.md
# risc_prog_loader

Byte-stream program loader that drives the instruction-memory write port of the `risc` core. It parses framed byte packets from the host pins and emits one memory write per payload byte with auto-incrementing address. It is the initiator side of the `inst_we` / `inst_address` / `inst_data` interface and sits between the top-level pin mapping and the `cpu` instance.

## Interface
- `ADDR_W`, 7: instruction address width.
- `DATA_W`, 8: data and byte-stream width.
- `SYNC`, 8'hA5: frame start byte.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `byte_in`  in  DATA_W  host byte.
- `byte_valid`  in  1  host presents `byte_in`.
- `byte_ready`  out  1  loader accepts `byte_in` this cycle.
- `abort`  in  1  synchronous frame abort.
- `inst_we`  out  1  one-cycle write strobe to `risc`.
- `inst_address`  out  ADDR_W  write address.
- `inst_data`  out  DATA_W  write data.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse at frame completion.
- `csum_err`  out  1  checksum mismatch on last frame; sticky.

## Operation
- A byte is transferred on any cycle where `byte_valid && byte_ready`.
- Frame format: `SYNC`, LEN, ADDR, LEN data bytes, CSUM.
- LEN = 0 means 128 bytes. ADDR[7] is ignored.
- States:
  - IDLE: ready=1. Accepting `SYNC` goes to LEN and clears `csum_err`. Any other byte is dropped and the state stays IDLE.
  - LEN: latch count, go to ADDR.
  - ADDR: latch address, clear checksum accumulator, go to DATA.
  - DATA: on accept, register `inst_data` = byte, `inst_address` = current address, assert `inst_we`. Add byte to accumulator mod 256 and decrement remaining. Go to WR.
  - WR: ready=0 for one cycle. Address increments by 1 and wraps 127→0. If remaining = 0, go to CSUM; otherwise go to DATA.
  - CSUM: on accept, set `csum_err` = (byte ≠ accumulator), pulse `done`, go to IDLE.
- `abort` takes priority over any byte in the same cycle. It returns the FSM to IDLE without a `done` pulse and leaves `csum_err` unchanged. Writes already issued are not undone.
- `inst_address` and `inst_data` hold their last values between writes.

## Timing
- `inst_we` is high exactly one cycle: the cycle after the data byte is accepted (WR cycle).
- Maximum rate is one data byte per 2 cycles. `byte_ready` is 0 in WR and 1 in every other state.
- `done` is high the cycle after the CSUM byte is accepted.
- `busy` is high from the cycle after `SYNC` is accepted through the `done` cycle (exclusive).
- `byte_ready` is combinational from state only, with no path from `byte_valid`.
- Reset (sync, `rst_n`=0 at an edge) takes priority over `abort`. It forces IDLE and drives all outputs to 0: `byte_ready`, `inst_we`, `inst_address`, `inst_data`, `busy`, `done`, `csum_err`. After reset release, `byte_ready`=1 on the first cycle. Reset mid-frame drops the frame with no further writes.

## Configuration
- `RISC_LOADER_CSUM_EN` defined: CSUM state, accumulator and `csum_err` behave as described above.
- Not defined: no CSUM byte in the frame. After the final WR cycle, go directly to IDLE and pulse `done` in the following cycle. `csum_err` is tied to 0.

## Structure
- Package `risc_loader_pkg` holds:
  - state enum (IDLE, LEN, ADDR, DATA, WR, CSUM);
  - `SYNC` default;
  - `ADDR_W` and `DATA_W` constants shared with the top-level wrapper.
- Implementation is a single flat module with no sub-module. The accumulator is an 8-bit adder inside the FSM block.

## Test plan
- Frame A5,03,10,11,22,33,66 → writes (0x10,0x11), (0x11,0x22), (0x12,0x33), each `inst_we` one cycle; `done` pulses; `csum_err`=0.
- Same frame with CSUM=0x67 → same three writes; `csum_err`=1, held until the next A5 is accepted.
- Frame A5,02,7F,AA,BB,65 → writes at 0x7F then 0x00 (address wrap).
- Bytes 00,FF then A5,01,05,9C,9C → leading bytes dropped; single write (0x05,0x9C).
- `byte_valid` held high continuously through a frame → `byte_ready` low every WR cycle; no byte lost or duplicated.
- `abort` after the 2nd data byte of a LEN=4 frame → 2 writes only, no `done`, `busy`=0 next cycle. Repeat with `rst_n`=0 instead: all outputs 0 next cycle.
